sobel_edge: RTL and testbench
=============================

Name: sobel_edge

Overview:
- Downstream neighbour of the grayscale stage; sits between the grayscale output FIFO and the image output FIFO.
- Consumes 8-bit grayscale pixels in raster order, one frame of WIDTH x HEIGHT.
- Emits one 8-bit Sobel gradient-magnitude pixel per input pixel, in the same raster order. Frame borders are forced to 0.

Parameters:
- WIDTH, 720, pixels per line (must be >= 3).
- HEIGHT, 540, lines per frame (must be >= 3).
- THRESHOLD, 64, binarization threshold; used only with SOBEL_THRESHOLD_EN.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_in_rd_en  output  1  pop request to the input FIFO.
- fifo_in_dout  input  8  grayscale pixel at the head of the input FIFO.
- fifo_in_empty  input  1  input FIFO empty.
- fifo_out_wr_en  output  1  push request to the output FIFO.
- fifo_out_din  output  8  edge pixel to the output FIFO.
- fifo_out_full  input  1  output FIFO full.

Behaviour:
- Single clock. Reset is asynchronous and active-high.
- State registers: state, window shift register (2*WIDTH+3 x 8 bits), in_count (0..WIDTH*HEIGHT), out_count (0..WIDTH*HEIGHT-1).
- Reset clears all of these: state=S_READ, window all 0, both counters 0.
- Outputs are combinational from registered state. Values during reset: fifo_in_rd_en=0, fifo_out_wr_en=0, fifo_out_din=0.
- Window taps:
  - p22 = newest entry; p21, p20 at offsets 1, 2.
  - p12, p11, p10 at offsets WIDTH, WIDTH+1, WIDTH+2.
  - p02, p01, p00 at offsets 2*WIDTH, 2*WIDTH+1, 2*WIDTH+2.
  - Center p11 is the pixel at index out_count.
- FSM:
  - S_READ:
    - rd_en = !fifo_in_empty.
    - On pop: shift fifo_in_dout into window, in_count++.
    - After the pop, if in_count (new value) > WIDTH+1, go to S_WRITE; otherwise stay in S_READ.
  - S_WRITE:
    - wr_en = !fifo_out_full; din = result.
    - On push, out_count++, then:
      - if out_count was WIDTH*HEIGHT-1: clear both counters and the window, go to S_READ (next frame);
      - else if in_count == WIDTH*HEIGHT: go to S_FLUSH;
      - else go to S_READ.
    - While full: hold state, no side effects.
  - S_FLUSH: shift 0 into window (no FIFO access), go to S_WRITE.
  - Unreachable encoding: go to S_READ.
- Never asserts rd_en and wr_en in the same cycle. Throughput is one pixel per 2 cycles when unblocked.
- Arithmetic (unsigned pixels, signed 11-bit intermediates):
  - Gx = (p02+2*p12+p22) - (p00+2*p10+p20).
  - Gy = (p20+2*p21+p22) - (p00+2*p01+p02).
  - mag = |Gx|+|Gy| (12-bit); result = min(mag, 255).
- Border: if center row == 0 or HEIGHT-1, or center column == 0 or WIDTH-1, result = 0.
  - Row and column are derived from out_count via row/col sub-counters, not division.
  - Zero-filled window entries (before first pixel, after flush) only ever affect border pixels.
- Output count per frame is exactly WIDTH*HEIGHT.
- Latency: output pixel k is pushed after input pixel k+WIDTH+1 has been popped. The final WIDTH+1 outputs come from S_FLUSH.
- Empty held in S_READ: stall indefinitely, no state change.
- Reset mid-frame: the frame is abandoned. The next pixel popped is treated as pixel (0,0).

Optional Feature:
- Macro SOBEL_THRESHOLD_EN.
- Defined: interior result = 255 if mag > THRESHOLD, else 0. Border pixels remain 0.
- Undefined: saturated magnitude as above. The THRESHOLD parameter is ignored.

Test Plan:
- WIDTH=4, HEIGHT=4, all pixels 100 -> 16 outputs, all 0; rd_en pulses exactly 16 times.
- WIDTH=4, HEIGHT=4, each row {0,0,10,10} -> interior (1,1),(1,2),(2,1),(2,2) = 40 (Gx=40, Gy=0); the other 12 outputs = 0.
- WIDTH=4, HEIGHT=4, each row {0,0,255,255} -> interior = 255 (mag 1020 saturated). With SOBEL_THRESHOLD_EN and THRESHOLD=64 -> interior = 255; with the {0,0,10,10} image -> interior = 0.
- Backpressure: hold fifo_out_full=1 for 20 cycles while in S_WRITE -> no wr_en and no rd_en for those cycles; fifo_out_din stable. After release, the output sequence is identical to the unstalled run.
- Empty bubbles: random fifo_in_empty gaps over two back-to-back 4x4 frames -> 32 outputs matching the golden model; second frame unaffected by the first.
- Reset asserted after 7 pops -> outputs 0 immediately, counters 0. A fresh 4x4 frame then yields the correct 16 outputs.

Source files
------------

// File: rtl/sobel_edge_if.sv
// FIFO-side handshake bundle for sobel_edge: pop port toward the grayscale
// FIFO and push port toward the image output FIFO.
interface sobel_edge_if;
   logic       fifo_in_rd_en;
   logic [7:0] fifo_in_dout;
   logic       fifo_in_empty;
   logic       fifo_out_wr_en;
   logic [7:0] fifo_out_din;
   logic       fifo_out_full;

   // Edge filter side: pops input pixels, pushes edge pixels.
   modport master (
      output fifo_in_rd_en,
      input  fifo_in_dout,
      input  fifo_in_empty,
      output fifo_out_wr_en,
      output fifo_out_din,
      input  fifo_out_full
   );

   // FIFO side of the same bundle.
   modport slave (
      input  fifo_in_rd_en,
      output fifo_in_dout,
      output fifo_in_empty,
      input  fifo_out_wr_en,
      input  fifo_out_din,
      output fifo_out_full
   );
endinterface

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel gradient-magnitude filter over a WIDTH x HEIGHT
// raster frame, borders forced to 0.
// Optional macro SOBEL_THRESHOLD_EN: binarize interior pixels against
// THRESHOLD (255 above, 0 otherwise) instead of saturating the magnitude.
//
// state   | meaning
// S_READ  | wait for / pop one input pixel into the window
// S_WRITE | push the result for the pixel centred at out_count
// S_FLUSH | input exhausted: shift a zero into the window for the tail rows
module sobel_edge #(
   parameter int WIDTH     = 720,
   parameter int HEIGHT    = 540,
   parameter int THRESHOLD = 64
) (
   input  logic          clock,
   input  logic          reset,
   sobel_edge_if.master  fifo
);
   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int WIN   = 2 * WIDTH + 3;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam int COL_W = $clog2(WIDTH);

   if (WIDTH < 3 || HEIGHT < 3 || THRESHOLD < 0) begin : g_param_check
      $error("sobel_edge: WIDTH/HEIGHT must be >= 3 and THRESHOLD >= 0");
   end

   typedef enum logic [1:0] {S_READ, S_WRITE, S_FLUSH} state_t;

   state_t             state_q, state_d;
   logic [7:0]         win_q [WIN];
   logic [7:0]         win_d [WIN];
   logic [CNT_W-1:0]   in_count_q, in_count_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;

   logic               rd_en, wr_en;
   logic [7:0]         result;

   function automatic logic signed [10:0] ext(input logic [7:0] v);
      return $signed({3'b000, v});
   endfunction

   logic [7:0] p00, p01, p02, p10, p12, p20, p21, p22;
   assign p22 = win_q[0];
   assign p21 = win_q[1];
   assign p20 = win_q[2];
   assign p12 = win_q[WIDTH];
   assign p10 = win_q[WIDTH+2];
   assign p02 = win_q[2*WIDTH];
   assign p01 = win_q[2*WIDTH+1];
   assign p00 = win_q[2*WIDTH+2];

   // Gradient magnitude for the centre tap, with border suppression.
   always_comb begin
      logic signed [10:0] gx, gy, ax, ay;
      logic [11:0]        mag;
      logic               border;
      gx = (ext(p02) + (ext(p12) <<< 1) + ext(p22))
         - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
      gy = (ext(p20) + (ext(p21) <<< 1) + ext(p22))
         - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
      ax  = gx[10] ? -gx : gx;
      ay  = gy[10] ? -gy : gy;
      mag = {1'b0, ax} + {1'b0, ay};
      border = (row_q == '0) || (row_q == ROW_W'(HEIGHT - 1)) ||
               (col_q == '0) || (col_q == COL_W'(WIDTH - 1));
`ifdef SOBEL_THRESHOLD_EN
      result = (mag > 12'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
      result = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif
      if (border) result = 8'h00;
   end

   // Handshake outputs decoded from the registered state; quiet in reset.
   assign rd_en = !reset && (state_q == S_READ)  && !fifo.fifo_in_empty;
   assign wr_en = !reset && (state_q == S_WRITE) && !fifo.fifo_out_full;
   assign fifo.fifo_in_rd_en  = rd_en;
   assign fifo.fifo_out_wr_en = wr_en;
   assign fifo.fifo_out_din   = (!reset && state_q == S_WRITE) ? result : 8'h00;

   // Next-state: FSM transitions, window shifting, counter bookkeeping.
   always_comb begin
      logic       shift_en, clear_all;
      logic [7:0] shift_val;
      state_d     = state_q;
      in_count_d  = in_count_q;
      out_count_d = out_count_q;
      row_d       = row_q;
      col_d       = col_q;
      shift_en    = 1'b0;
      shift_val   = 8'h00;
      clear_all   = 1'b0;
      case (state_q)
         S_READ: begin
            if (rd_en) begin
               shift_en   = 1'b1;
               shift_val  = fifo.fifo_in_dout;
               in_count_d = in_count_q + 1'b1;
               if (in_count_d > CNT_W'(WIDTH + 1)) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (wr_en) begin
               if (out_count_q == CNT_W'(TOTAL - 1)) begin
                  clear_all = 1'b1;
                  state_d   = S_READ;
               end else begin
                  out_count_d = out_count_q + 1'b1;
                  if (col_q == COL_W'(WIDTH - 1)) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
                  state_d = (in_count_q == CNT_W'(TOTAL)) ? S_FLUSH : S_READ;
               end
            end
         end
         S_FLUSH: begin
            shift_en = 1'b1;
            state_d  = S_WRITE;
         end
         default: state_d = S_READ;
      endcase

      win_d = win_q;
      if (clear_all) begin
         for (int i = 0; i < WIN; i++) win_d[i] = 8'h00;
         in_count_d  = '0;
         out_count_d = '0;
         row_d       = '0;
         col_d       = '0;
      end else if (shift_en) begin
         win_d[0] = shift_val;
         for (int i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_READ;
         in_count_q  <= '0;
         out_count_q <= '0;
         row_q       <= '0;
         col_q       <= '0;
         for (int i = 0; i < WIN; i++) win_q[i] <= 8'h00;
      end else begin
         state_q     <= state_d;
         in_count_q  <= in_count_d;
         out_count_q <= out_count_d;
         row_q       <= row_d;
         col_q       <= col_d;
         for (int i = 0; i < WIN; i++) win_q[i] <= win_d[i];
      end
   end
endmodule

// File: tb/tb_sobel_edge.sv
// Self-checking bench for sobel_edge on a 4x4 frame against a direct 2-D
// Sobel reference model.
module tb_sobel_edge;
   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;
   localparam int THR = 64;

   logic clock = 1'b0;
   logic reset;
   sobel_edge_if ifc();

   sobel_edge #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(THR)) dut (
      .clock (clock),
      .reset (reset),
      .fifo  (ifc.master)
   );

   always #5 clock = ~clock;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         in_q[$];
   int         out_q[$];
   int         rd_cnt = 0;
   logic       s_rd, s_wr;
   logic [7:0] s_din;
   int         img [0:2*N-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int px(input int base, input int r, input int c);
      return img[base + r*W + c];
   endfunction

   function automatic int golden(input int base, input int r, input int c);
      int gx, gy, mag;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
      gx = (px(base,r-1,c+1) + 2*px(base,r,c+1) + px(base,r+1,c+1))
         - (px(base,r-1,c-1) + 2*px(base,r,c-1) + px(base,r+1,c-1));
      gy = (px(base,r+1,c-1) + 2*px(base,r+1,c) + px(base,r+1,c+1))
         - (px(base,r-1,c-1) + 2*px(base,r-1,c) + px(base,r-1,c+1));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
      return (mag > THR) ? 255 : 0;
`else
      return (mag > 255) ? 255 : mag;
`endif
   endfunction

   task automatic cycle(input bit gap, input bit full);
      @(negedge clock);
      ifc.fifo_in_empty = (in_q.size() == 0) || gap;
      ifc.fifo_in_dout  = (in_q.size() != 0) ? 8'(in_q[0]) : 8'd0;
      ifc.fifo_out_full = full;
      #1;
      s_rd  = ifc.fifo_in_rd_en;
      s_wr  = ifc.fifo_out_wr_en;
      s_din = ifc.fifo_out_din;
      check("rd_wr_exclusive", 32'(s_rd & s_wr), 0);
      @(posedge clock);
      if (s_rd) begin
         void'(in_q.pop_front());
         rd_cnt++;
      end
      if (s_wr && !full) out_q.push_back(int'(s_din));
   endtask

   task automatic stall_seq();
      int         k = 0;
      logic [7:0] din0;
      cycle(0, 1);
      while (s_rd && k < 10) begin
         cycle(0, 1);
         k++;
      end
      check("stall_entry_rd", 32'(s_rd), 0);
      din0 = s_din;
      repeat (20) begin
         cycle(0, 1);
         check("stall_rd", 32'(s_rd), 0);
         check("stall_wr", 32'(s_wr), 0);
         check("stall_din", 32'(s_din), 32'(din0));
      end
   endtask

   task automatic run_frames(input int nf, input int gap_pct, input int stall_at, input string tag);
      int exp_n    = nf * N;
      int start_rd = rd_cnt;
      int budget   = 0;
      bit stalled  = 0;
      out_q.delete();
      for (int i = 0; i < exp_n; i++) in_q.push_back(img[i]);
      while (out_q.size() < exp_n && budget < 3000) begin
         if (stall_at >= 0 && !stalled && out_q.size() == stall_at) begin
            stall_seq();
            stalled = 1;
         end else begin
            cycle($urandom_range(0, 99) < gap_pct, 0);
         end
         budget++;
      end
      check({tag, "_count"}, out_q.size(), exp_n);
      for (int k = 0; k < exp_n && k < out_q.size(); k++) begin
         int p = k % N;
         check($sformatf("%s_px%0d", tag, k), out_q[k], golden((k / N) * N, p / W, p % W));
      end
      check({tag, "_rd_pulses"}, rd_cnt - start_rd, exp_n);
      repeat (10) cycle(0, 0);
      check({tag, "_no_extra_out"}, out_q.size(), exp_n);
   endtask

   initial begin
      int start_rd, b;
      reset = 1'b1;
      ifc.fifo_in_empty = 1'b1;
      ifc.fifo_in_dout  = 8'd0;
      ifc.fifo_out_full = 1'b0;
      repeat (2) @(negedge clock);
      ifc.fifo_in_empty = 1'b0;
      ifc.fifo_in_dout  = 8'd77;
      #1;
      check("reset_rd_en", 32'(ifc.fifo_in_rd_en), 0);
      check("reset_wr_en", 32'(ifc.fifo_out_wr_en), 0);
      check("reset_din", 32'(ifc.fifo_out_din), 0);
      ifc.fifo_in_empty = 1'b1;
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < N; i++) img[i] = 100;
      run_frames(1, 0, -1, "flat");

      for (int i = 0; i < N; i++) img[i] = ((i % W) >= 2) ? 10 : 0;
      run_frames(1, 0, -1, "step10");

      for (int i = 0; i < N; i++) img[i] = ((i % W) >= 2) ? 255 : 0;
      run_frames(1, 0, -1, "step255");

      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      run_frames(1, 0, 6, "stall");

      for (int i = 0; i < 2*N; i++) img[i] = $urandom_range(0, 255);
      run_frames(2, 30, -1, "b2b");

      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      for (int i = 0; i < N; i++) in_q.push_back(img[i]);
      out_q.delete();
      start_rd = rd_cnt;
      b = 0;
      while (rd_cnt - start_rd < 7 && b < 200) begin
         cycle(0, 0);
         b++;
      end
      check("pre_reset_pops", rd_cnt - start_rd, 7);
      @(negedge clock);
      ifc.fifo_in_empty = 1'b0;
      ifc.fifo_out_full = 1'b0;
      reset = 1'b1;
      #1;
      check("midreset_rd_en", 32'(ifc.fifo_in_rd_en), 0);
      check("midreset_wr_en", 32'(ifc.fifo_out_wr_en), 0);
      check("midreset_din", 32'(ifc.fifo_out_din), 0);
      in_q.delete();
      ifc.fifo_in_empty = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      run_frames(1, 20, -1, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
